// File: rtl/blob_statistics.sv
// blob_statistics
//   Accumulates bright-pixel statistics (count, coordinate sums, bounding box)
//   over a binarized video frame and exposes the committed results of the
//   last complete frame on a custom-instruction (CI) bus.
//
// Ports
//   systemClock           sole clock, rising edge
//   reset                 synchronous, active-high
//   pixelValid            qualifies pixelData/pixelSof/pixelEol/pixelEof
//   pixelData[7:0]        binarized pixel, bright when bit 7 is set
//   pixelSof/Eol/Eof      first pixel of frame / last of line / last of frame
//   ciStart, ciCke, ciN   CI handshake and instruction number
//   ciValueA, ciValueB    CI operands (A selects register/command, B = data)
//   ciResult, ciDone      CI result and same-cycle completion
//   frameDone             one-cycle pulse while a frame is being committed
module blob_statistics #(
  parameter logic [7:0]  CUSTOM_INSTRUCTION_ID = 8'd0,
  parameter logic [10:0] MAX_COORD             = 11'd2047
) (
  input  logic        systemClock,
  input  logic        reset,
  input  logic        pixelValid,
  input  logic [7:0]  pixelData,
  input  logic        pixelSof,
  input  logic        pixelEol,
  input  logic        pixelEof,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic [31:0] ciResult,
  output logic        ciDone,
  output logic        frameDone
);

  typedef enum logic [1:0] {WAIT_SOF, ACCUM, COMMIT} state_t;

  localparam logic [10:0] MIN_CLEAR = 11'h7FF;

  state_t state_reg, state_next;

  logic [10:0] x_reg, y_reg;
  logic [31:0] count_reg, sumx_reg, sumy_reg;
  logic [10:0] minx_reg, miny_reg, maxx_reg, maxy_reg;
  logic        acc_ovf_reg;

  logic [31:0] res_count_reg, res_sumx_reg, res_sumy_reg;
  logic [10:0] res_minx_reg, res_miny_reg, res_maxx_reg, res_maxy_reg;
  logic        res_ovf_reg;
  logic [15:0] frame_counter_reg;
  logic        frame_ready_reg, frame_error_reg, enable_reg;

  // Only bit 7 of the pixel and bit 0 of operand B carry information.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, pixelData[6:0], ciValueB[31:1]};

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v >= MAX_COORD) ? MAX_COORD : v + 11'd1;
  endfunction

  // ---------------------------------------------------------------- pixel path
  logic        take_pixel, restart, bright;
  logic [10:0] pix_x, pix_y;
  logic [31:0] base_count, base_sumx, base_sumy;
  logic [10:0] base_minx, base_miny, base_maxx, base_maxy;
  logic        base_ovf;
  logic        count_carry, sumx_carry, sumy_carry;
  logic [31:0] count_inc, sumx_add, sumy_add;
  logic [31:0] count_next, sumx_next, sumy_next;
  logic [10:0] minx_next, miny_next, maxx_next, maxy_next;
  logic        ovf_next;
  logic [10:0] x_next, y_next;

  always_comb begin
    bright     = pixelData[7];
    take_pixel = pixelValid & (((state_reg == WAIT_SOF) & pixelSof & enable_reg)
                               | (state_reg == ACCUM));
    // A SOF inside a frame throws away the partial frame and starts over.
    restart    = (state_reg == ACCUM) & pixelValid & pixelSof;

    // The first pixel of a frame always sits at the origin.
    pix_x = ((state_reg == WAIT_SOF) | restart) ? 11'd0 : x_reg;
    pix_y = ((state_reg == WAIT_SOF) | restart) ? 11'd0 : y_reg;

    // Accumulators are already clear in WAIT_SOF; on restart use clear values.
    base_count = restart ? 32'd0     : count_reg;
    base_sumx  = restart ? 32'd0     : sumx_reg;
    base_sumy  = restart ? 32'd0     : sumy_reg;
    base_minx  = restart ? MIN_CLEAR : minx_reg;
    base_miny  = restart ? MIN_CLEAR : miny_reg;
    base_maxx  = restart ? 11'd0     : maxx_reg;
    base_maxy  = restart ? 11'd0     : maxy_reg;
    base_ovf   = restart ? 1'b0      : acc_ovf_reg;

    {count_carry, count_inc} = {1'b0, base_count} + 33'd1;
    {sumx_carry, sumx_add}   = {1'b0, base_sumx} + {22'd0, pix_x};
    {sumy_carry, sumy_add}   = {1'b0, base_sumy} + {22'd0, pix_y};

    count_next = base_count;
    sumx_next  = base_sumx;
    sumy_next  = base_sumy;
    minx_next  = base_minx;
    miny_next  = base_miny;
    maxx_next  = base_maxx;
    maxy_next  = base_maxy;
    ovf_next   = base_ovf;
    if (bright) begin
      count_next = count_inc;
      sumx_next  = sumx_add;
      sumy_next  = sumy_add;
      if (pix_x < base_minx) minx_next = pix_x;
      if (pix_y < base_miny) miny_next = pix_y;
      if (pix_x > base_maxx) maxx_next = pix_x;
      if (pix_y > base_maxy) maxy_next = pix_y;
      ovf_next = base_ovf | count_carry | sumx_carry | sumy_carry;
    end

    // End of frame also ends the line.
    if (pixelEol | pixelEof) begin
      x_next = 11'd0;
      y_next = sat_inc(pix_y);
    end else begin
      x_next = sat_inc(pix_x);
      y_next = pix_y;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_next = state_reg;
    frameDone  = 1'b0;
    case (state_reg)
      WAIT_SOF: if (take_pixel) state_next = pixelEof ? COMMIT : ACCUM;
      ACCUM:    if (pixelValid & pixelEof) state_next = COMMIT;
      COMMIT: begin
        frameDone  = 1'b1;
        state_next = WAIT_SOF;
      end
      default:  state_next = WAIT_SOF;
    endcase
  end

  // ---------------------------------------------------------------- CI decode
  logic is_my_ci, ci_clear, ci_enable;

  always_comb begin
    is_my_ci  = ciStart & ciCke & (ciN == CUSTOM_INSTRUCTION_ID);
    ciDone    = is_my_ci;
    ci_clear  = is_my_ci & (ciValueA == 32'd6);
    ci_enable = is_my_ci & (ciValueA == 32'd7);
    ciResult  = 32'd0;
    if (is_my_ci) begin
      case (ciValueA)
        32'd0: ciResult = {frame_counter_reg, 13'd0, frame_error_reg, res_ovf_reg, frame_ready_reg};
        32'd1: ciResult = res_count_reg;
        32'd2: ciResult = res_sumx_reg;
        32'd3: ciResult = res_sumy_reg;
        32'd4: ciResult = {5'd0, res_miny_reg, 5'd0, res_minx_reg};
        32'd5: ciResult = {5'd0, res_maxy_reg, 5'd0, res_maxx_reg};
        default: ciResult = 32'd0;
      endcase
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge systemClock) begin
    if (reset) begin
      state_reg         <= WAIT_SOF;
      x_reg             <= 11'd0;
      y_reg             <= 11'd0;
      count_reg         <= 32'd0;
      sumx_reg          <= 32'd0;
      sumy_reg          <= 32'd0;
      minx_reg          <= MIN_CLEAR;
      miny_reg          <= MIN_CLEAR;
      maxx_reg          <= 11'd0;
      maxy_reg          <= 11'd0;
      acc_ovf_reg       <= 1'b0;
      res_count_reg     <= 32'd0;
      res_sumx_reg      <= 32'd0;
      res_sumy_reg      <= 32'd0;
      res_minx_reg      <= 11'd0;
      res_miny_reg      <= 11'd0;
      res_maxx_reg      <= 11'd0;
      res_maxy_reg      <= 11'd0;
      res_ovf_reg       <= 1'b0;
      frame_counter_reg <= 16'd0;
      frame_ready_reg   <= 1'b0;
      frame_error_reg   <= 1'b0;
      enable_reg        <= 1'b1;
    end else begin
      state_reg <= state_next;

      if (take_pixel) begin
        x_reg       <= x_next;
        y_reg       <= y_next;
        count_reg   <= count_next;
        sumx_reg    <= sumx_next;
        sumy_reg    <= sumy_next;
        minx_reg    <= minx_next;
        miny_reg    <= miny_next;
        maxx_reg    <= maxx_next;
        maxy_reg    <= maxy_next;
        acc_ovf_reg <= ovf_next;
      end

      if (state_reg == COMMIT) begin
        res_count_reg     <= count_reg;
        res_sumx_reg      <= sumx_reg;
        res_sumy_reg      <= sumy_reg;
        res_minx_reg      <= minx_reg;
        res_miny_reg      <= miny_reg;
        res_maxx_reg      <= maxx_reg;
        res_maxy_reg      <= maxy_reg;
        res_ovf_reg       <= acc_ovf_reg;
        frame_counter_reg <= frame_counter_reg + 16'd1;
        x_reg             <= 11'd0;
        y_reg             <= 11'd0;
        count_reg         <= 32'd0;
        sumx_reg          <= 32'd0;
        sumy_reg          <= 32'd0;
        minx_reg          <= MIN_CLEAR;
        miny_reg          <= MIN_CLEAR;
        maxx_reg          <= 11'd0;
        maxy_reg          <= 11'd0;
        acc_ovf_reg       <= 1'b0;
      end

      // A commit outranks a simultaneous clear of frameReady.
      if (state_reg == COMMIT) frame_ready_reg <= 1'b1;
      else if (ci_clear)       frame_ready_reg <= 1'b0;

      if (restart)       frame_error_reg <= 1'b1;
      else if (ci_clear) frame_error_reg <= 1'b0;

      if (ci_enable) enable_reg <= ciValueB[0];
    end
  end

endmodule

// File: tb/tb_blob_statistics.sv
module tb_blob_statistics;

  localparam logic [7:0] ID = 8'h05;

  logic        systemClock = 1'b0;
  logic        reset;
  logic        pixelValid;
  logic [7:0]  pixelData;
  logic        pixelSof, pixelEol, pixelEof;
  logic        ciStart, ciCke;
  logic [7:0]  ciN;
  logic [31:0] ciValueA, ciValueB;
  logic [31:0] ciResult;
  logic        ciDone;
  logic        frameDone;

  always #5 systemClock = ~systemClock;

  blob_statistics #(
    .CUSTOM_INSTRUCTION_ID(ID),
    .MAX_COORD(11'd2047)
  ) dut (
    .systemClock(systemClock),
    .reset(reset),
    .pixelValid(pixelValid),
    .pixelData(pixelData),
    .pixelSof(pixelSof),
    .pixelEol(pixelEol),
    .pixelEof(pixelEof),
    .ciStart(ciStart),
    .ciCke(ciCke),
    .ciN(ciN),
    .ciValueA(ciValueA),
    .ciValueB(ciValueB),
    .ciResult(ciResult),
    .ciDone(ciDone),
    .frameDone(frameDone)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected CI results, in issue order.
  logic [31:0] exp_q[$];
  string       name_q[$];

  // Reference model state.
  logic        bm [8][8];
  logic [31:0] m_count, m_sumx, m_sumy;
  logic [10:0] m_minx, m_miny, m_maxx, m_maxy;
  logic [15:0] m_counter;
  logic        m_ready, m_error, m_ovf;
  int          exp_done = 0;
  int          done_cnt = 0;

  // Monitor: pops and compares on every CI completion; counts frameDone.
  logic [31:0] mon_exp;
  string       mon_name;
  always @(negedge systemClock) begin
    if (frameDone) done_cnt++;
    if (ciDone) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ciDone: ciResult=%h with no expected entry", ciResult);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (ciResult !== mon_exp) begin
          errors++;
          $display("FAIL %s: ciResult=%h expected %h", mon_name, ciResult, mon_exp);
        end else begin
          $display("ci %s: ciResult=%h", mon_name, ciResult);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge systemClock);
    #1;
  endtask

  task automatic pixel(input logic br, input logic sof, input logic eol, input logic eof);
    pixelValid = 1'b1;
    pixelData  = {br, 7'($urandom_range(0, 127))};
    pixelSof   = sof;
    pixelEol   = eol;
    pixelEof   = eof;
    cyc();
    pixelValid = 1'b0;
    pixelData  = 8'd0;
    pixelSof   = 1'b0;
    pixelEol   = 1'b0;
    pixelEof   = 1'b0;
  endtask

  task automatic ci(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv, input string nm);
    ciStart  = 1'b1;
    ciCke    = 1'b1;
    ciN      = ID;
    ciValueA = a;
    ciValueB = b;
    exp_q.push_back(expv);
    name_q.push_back(nm);
    cyc();
    ciStart  = 1'b0;
    ciCke    = 1'b0;
    ciN      = 8'd0;
    ciValueA = 32'd0;
    ciValueB = 32'd0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end else begin
      $display("check %s: %h", nm, act);
    end
  endtask

  // Statistics of the bright map over a w x h frame, straight from the definition.
  task automatic compute_model(input int w, input int h);
    m_count = 0; m_sumx = 0; m_sumy = 0;
    m_minx = 11'h7FF; m_miny = 11'h7FF; m_maxx = 0; m_maxy = 0;
    m_ovf = 1'b0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        if (bm[y][x]) begin
          m_count += 1;
          m_sumx  += x;
          m_sumy  += y;
          if (x < m_minx) m_minx = 11'(x);
          if (y < m_miny) m_miny = 11'(y);
          if (x > m_maxx) m_maxx = 11'(x);
          if (y > m_maxy) m_maxy = 11'(y);
        end
  endtask

  task automatic fill_bm(input int pct);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        bm[y][x] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic send_frame(input int w, input int h, input bit gaps);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        if (gaps) repeat ($urandom_range(0, 2)) cyc();
        pixel(bm[y][x], (x == 0 && y == 0), (x == w - 1), (x == w - 1 && y == h - 1));
      end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && done_cnt != exp_done; i++) cyc();
    cyc();
    check("frameDone_count", 32'(done_cnt), 32'(exp_done));
  endtask

  task automatic commit_model();
    m_counter = m_counter + 16'd1;
    m_ready   = 1'b1;
    exp_done++;
  endtask

  task automatic read_all();
    ci(32'd0, 32'd0, {m_counter, 13'd0, m_error, m_ovf, m_ready}, "status");
    ci(32'd1, 32'd0, m_count, "count");
    ci(32'd2, 32'd0, m_sumx, "sumX");
    ci(32'd3, 32'd0, m_sumy, "sumY");
    ci(32'd4, 32'd0, {5'd0, m_miny, 5'd0, m_minx}, "min");
    ci(32'd5, 32'd0, {5'd0, m_maxy, 5'd0, m_maxx}, "max");
  endtask

  task automatic model_reset();
    m_count = 0; m_sumx = 0; m_sumy = 0;
    m_minx = 0; m_miny = 0; m_maxx = 0; m_maxy = 0;
    m_counter = 0; m_ready = 0; m_error = 0; m_ovf = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pixelValid = 0; pixelData = 0; pixelSof = 0; pixelEol = 0; pixelEof = 0;
    ciStart = 0; ciCke = 0; ciN = 0; ciValueA = 0; ciValueB = 0;
    model_reset();
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    // Reset state: every result register reads zero.
    read_all();
    check("frameDone_after_reset", 32'(done_cnt), 32'd0);

    // 4x2 frame, bright at (1,0) and (3,1).
    fill_bm(0);
    bm[0][1] = 1'b1;
    bm[1][3] = 1'b1;
    send_frame(4, 2, 1'b0);
    compute_model(4, 2);
    commit_model();
    wait_done();
    ci(32'd0, 32'd0, 32'h00010001, "status_directed");
    read_all();

    // All-dark 4x2 frame.
    fill_bm(0);
    send_frame(4, 2, 1'b1);
    compute_model(4, 2);
    commit_model();
    wait_done();
    read_all();

    // SOF arrives at (2,1) of a frame: partial frame discarded, error flagged.
    fill_bm(100);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        if (!(y == 1 && x >= 2)) pixel(bm[y][x], (x == 0 && y == 0), (x == 3), 1'b0);
    fill_bm(50);
    send_frame(4, 2, 1'b0);
    compute_model(4, 2);
    m_error = 1'b1;
    commit_model();
    wait_done();
    read_all();

    // Clear issued in the COMMIT cycle: ready stays set, error clears.
    fill_bm(50);
    send_frame(3, 3, 1'b0);
    ci(32'd6, 32'd0, 32'd0, "clear_on_commit");
    compute_model(3, 3);
    commit_model();
    m_error = 1'b0;
    wait_done();
    read_all();

    // CI addressed to another instruction number is ignored.
    ciStart = 1'b1; ciCke = 1'b1; ciN = ID + 8'd1; ciValueA = 32'd1;
    @(negedge systemClock);
    check("foreign_ciDone", {31'd0, ciDone}, 32'd0);
    check("foreign_ciResult", ciResult, 32'd0);
    cyc();
    ciStart = 1'b0; ciCke = 1'b0; ciN = 8'd0; ciValueA = 32'd0;

    // Clear outside a commit drops frameReady.
    ci(32'd6, 32'd0, 32'd0, "clear");
    m_ready = 1'b0;
    ci(32'd0, 32'd0, {m_counter, 13'd0, m_error, m_ovf, m_ready}, "status_cleared");

    // Disabled: a frame is ignored entirely; re-enabled: next frame commits.
    ci(32'd7, 32'd0, 32'd0, "disable");
    fill_bm(60);
    send_frame(4, 2, 1'b0);
    repeat (10) cyc();
    check("frameDone_while_disabled", 32'(done_cnt), 32'(exp_done));
    read_all();
    ci(32'd7, 32'd1, 32'd0, "enable");
    fill_bm(60);
    send_frame(5, 2, 1'b1);
    compute_model(5, 2);
    commit_model();
    wait_done();
    read_all();

    // Randomised frames.
    for (int n = 0; n < 8; n++) begin
      int w, h;
      w = $urandom_range(1, 8);
      h = $urandom_range(1, 6);
      fill_bm($urandom_range(0, 100));
      send_frame(w, h, 1'($urandom_range(0, 1)));
      compute_model(w, h);
      commit_model();
      wait_done();
      read_all();
    end

    // Reset in the middle of a frame: no commit, everything back to zero.
    pixel(1'b1, 1'b1, 1'b0, 1'b0);
    pixel(1'b1, 1'b0, 1'b0, 1'b0);
    pixel(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    pixel(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (5) cyc();
    check("frameDone_after_midframe_reset", 32'(done_cnt), 32'(exp_done));
    model_reset();
    read_all();

    repeat (3) cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blob_statistics.md
BLOB_STATISTICS -- requirements
Module: blob_statistics

Interface
REQ-001 SHALL have parameter CUSTOM_INSTRUCTION_ID, default 8'd0, custom-instruction number this block answers to.
REQ-002 SHALL have parameter MAX_COORD, default 11'd2047, saturation limit for x/y counters.
REQ-003 SHALL have port systemClock  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high.
REQ-005 SHALL have port pixelValid  in  1  qualifies all pixel* inputs for one cycle.
REQ-006 SHALL have port pixelData  in  8  binarized pixel, already in systemClock domain; bright when pixelData[7]=1.
REQ-007 SHALL have port pixelSof  in  1  marks first pixel of a frame (valid only with pixelValid).
REQ-008 SHALL have port pixelEol  in  1  marks last pixel of a line.
REQ-009 SHALL have port pixelEof  in  1  marks last pixel of a frame (also treated as end of line).
REQ-010 SHALL have ports ciStart, ciCke (in 1), ciN (in 8), ciValueA, ciValueB (in 32), ciResult (out 32), ciDone (out 1), standard custom-instruction bus.
REQ-011 SHALL have port frameDone  out  1  one-cycle pulse when a frame's results are committed.

Function
REQ-012 SHALL use FSM states WAIT_SOF, ACCUM, COMMIT.
REQ-013 WAIT_SOF: ignore pixels until pixelValid&pixelSof&enable; that pixel is processed as x=0,y=0 and state -> ACCUM (-> COMMIT if pixelEof also set).
REQ-014 ACCUM: each valid pixel processed at current (x,y); x increments after it; on pixelEol x<=0, y increments; on pixelEof state -> COMMIT.
REQ-015 x and y SHALL be 11-bit, saturating at MAX_COORD, never wrapping.
REQ-016 A bright valid pixel SHALL increment count (32-bit), add x to sumX and y to sumY (32-bit, modulo), and update minX/minY/maxX/maxY.
REQ-017 Any carry out of count, sumX or sumY SHALL set overflow for the current frame.
REQ-018 pixelSof in ACCUM SHALL discard the partial frame, set sticky frameError, and restart accumulation with that pixel as x=0,y=0.
REQ-019 COMMIT (one cycle): copy accumulators to result registers, increment 16-bit frameCounter (wrapping), set frameReady, pulse frameDone, clear accumulators, -> WAIT_SOF; pixels arriving in COMMIT are dropped.
REQ-020 Accumulator clear values: count/sums 0, minX/minY 11'h7FF, maxX/maxY 0; an empty frame therefore commits min=7FF, max=0, count=0.
REQ-021 Results SHALL be readable via CI the cycle after COMMIT.
REQ-022 isMyCi = ciStart & ciCke & (ciN==CUSTOM_INSTRUCTION_ID); ciDone=isMyCi combinationally, same cycle.
REQ-023 ciResult SHALL be 0 when isMyCi=0, else selected by ciValueA: 0 status {frameCounter, 13'b0, frameError, overflow, frameReady}; 1 count; 2 sumX; 3 sumY; 4 {5'b0,minY,5'b0,minX}; 5 {5'b0,maxY,5'b0,maxX}; other 0.
REQ-024 ciValueA=6 SHALL clear frameReady and frameError; ciValueA=7 SHALL set enable<=ciValueB[0].
REQ-025 Clear (ciValueA=6) in the same cycle as COMMIT: COMMIT wins, frameReady=1; frameError still cleared.
REQ-026 enable=0 SHALL only block leaving WAIT_SOF; a frame in progress completes normally.

Reset
REQ-027 On reset: state WAIT_SOF, x=y=0, accumulators to REQ-020 values, result registers all 0, frameCounter 0, frameReady/frameError/overflow 0, enable 1, frameDone 0.
REQ-028 Reset mid-frame SHALL discard the frame with no commit and no frameDone.

Verification
REQ-029 4x2 frame, bright pixels at (1,0),(3,1) -> frameDone once; count=2, sumX=4, sumY=1, min=(1,0), max=(3,1), status=0x00010001.
REQ-030 All-dark 4x2 frame -> count=0, minX=minY=0x7FF, maxX=maxY=0, frameReady=1.
REQ-031 SOF at x=2,y=1 of first frame, then full 4x2 frame -> frameError=1, results reflect second frame only, frameCounter=1.
REQ-032 CI ciValueA=6 on COMMIT cycle -> frameReady=1, frameError=0; CI with ciN!=ID -> ciDone=0, ciResult=0.
REQ-033 enable=0 via ciValueA=7, ciValueB=0, then SOF -> no accumulation, no frameDone; re-enable -> next frame committed.
REQ-034 Reset asserted mid-frame -> no frameDone, all CI reads 0 except minY/minX read 0.
